// File: rtl/bp_commit_update_queue.sv
// Branch predictor commit-side update queue: in-order FIFO of retired branches
// replayed to the predictor as spaced single-cycle branch_commit pulses.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   commit_valid/pc/taken/    ROB retiring-branch push interface
//   commit_mispred
//   commit_ready              queue accepts a push this cycle (not full)
//   upd_commit/upd_pc/        predictor training pulse and payload
//   upd_taken
//   occupancy                 entries currently queued
//   branch_count              accepted branches since reset (saturating)
//   mispred_count             accepted mispredicted branches (saturating)
module bp_commit_update_queue #(
    parameter int DEPTH      = 8,
    parameter int UPD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic                     commit_taken,
    input  logic                     commit_mispred,
    output logic                     commit_ready,
    output logic                     upd_commit,
    output logic [31:0]              upd_pc,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispred_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (UPD_CYCLES > 2) ? $clog2(UPD_CYCLES - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [32:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic [31:0]     branch_cnt, mispred_cnt;
    logic [32:0]     head;
    logic            push, pop;

    assign commit_ready  = (count != (AW+1)'(DEPTH));
    assign push          = commit_valid && commit_ready;
    assign pop           = (state == ISSUE);
    assign upd_commit    = (state == ISSUE);
    assign occupancy     = count;
    assign branch_count  = branch_cnt;
    assign mispred_count = mispred_cnt;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    // Entering ISSUE never coincides with a pop, so rd_ptr is the head.
    // An empty queue being pushed this cycle supplies the head directly so
    // the payload register is ready on the pulse cycle.
    assign head = (count == '0) ? {commit_pc, commit_taken} : mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (count_nxt != '0)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                wait_nxt  = CW'(UPD_CYCLES - 2);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0)
                    state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
                else
                    wait_nxt = wait_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {commit_pc, commit_taken};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            count    <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (state_nxt == ISSUE)
                {upd_pc, upd_taken} <= head;
            if (push && branch_cnt != '1)
                branch_cnt <= branch_cnt + 1'b1;
            if (push && commit_mispred && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_commit_update_queue.sv
// Testbench for bp_commit_update_queue: queue-based scoreboard plus a
// cycle-level reference model of pulse spacing, fullness and counters.
module tb_bp_commit_update_queue;

    localparam int DEPTH = 8;
    localparam int UPD   = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        commit_valid = 0;
    logic [31:0] commit_pc = '0;
    logic        commit_taken = 0;
    logic        commit_mispred = 0;
    logic        commit_ready;
    logic        upd_commit;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [3:0]  occupancy;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    bp_commit_update_queue #(.DEPTH(DEPTH), .UPD_CYCLES(UPD)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_taken(commit_taken), .commit_mispred(commit_mispred),
        .commit_ready(commit_ready), .upd_commit(upd_commit),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .occupancy(occupancy),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [32:0] exp_q[$];

    int          mcount;
    int          last_pulse;
    int          t;
    logic [31:0] mbc, mmc;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        mcount = 0;
        last_pulse = -100;
        mbc = '0;
        mmc = '0;
        exp_q.delete();
    endtask

    // One clock cycle: check outputs against the model, drive inputs,
    // advance the model to the end of the cycle.
    task automatic cycle(input logic v, input logic [31:0] pc,
                         input logic tk, input logic mp);
        bit pulse, rdy, acc;
        @(negedge clk);
        pulse = (mcount > 0) && (t - last_pulse >= UPD);
        rdy   = (mcount != DEPTH);
        chk("upd_commit", {31'b0, upd_commit}, {31'b0, pulse});
        chk("commit_ready", {31'b0, commit_ready}, {31'b0, rdy});
        chk("occupancy", {28'b0, occupancy}, mcount);
        chk("branch_count", branch_count, mbc);
        chk("mispred_count", mispred_count, mmc);
        commit_valid   = v;
        commit_pc      = pc;
        commit_taken   = tk;
        commit_mispred = mp;
        acc = v && rdy;
        if (acc) begin
            exp_q.push_back({pc, tk});
            if (mbc != 32'hFFFF_FFFF) mbc = mbc + 1;
            if (mp && mmc != 32'hFFFF_FFFF) mmc = mmc + 1;
        end
        mcount = mcount + int'(acc) - int'(pulse);
        if (pulse) last_pulse = t;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && upd_commit) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pulse_unexpected: got pc %h with empty queue",
                         upd_pc);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("upd_pc", upd_pc, e[32:1]);
                chk("upd_taken", {31'b0, upd_taken}, {31'b0, e[0]});
            end
        end
    end

    initial begin
        t = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, commit_ready}, 32'd1);
        chk("rst_upd_commit", {31'b0, upd_commit}, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_occupancy", {28'b0, occupancy}, 32'd0);
        rst = 0;

        // single push, 1-cycle latency
        cycle(1, 32'h0000_1004, 1, 0);
        idle(8);

        // three back-to-back pushes, pulses spaced UPD apart
        cycle(1, 32'h0000_2000, 0, 0);
        cycle(1, 32'h0000_2004, 1, 1);
        cycle(1, 32'h0000_2008, 0, 0);
        idle(14);

        // valid held high: fill to full, backpressure, wrap
        for (int i = 0; i < 40; i++)
            cycle(1, 32'h0000_3000 + 32'(i * 4), i[0], i[1]);
        idle(50);

        // counter check: 5 commits, mispred on 2nd and 4th
        for (int i = 0; i < 5; i++)
            cycle(1, 32'h0000_4000 + 32'(i * 4), 0, (i == 1 || i == 3));
        idle(30);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 99) < 45), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1));
        idle(50);

        // reset mid-WAIT with three entries queued
        for (int i = 0; i < 4; i++)
            cycle(1, 32'h0000_5000 + 32'(i * 4), 1, 1);
        @(posedge clk);
        #2;
        commit_valid = 0;
        rst = 1;
        #1;
        chk("arst_upd_commit", {31'b0, upd_commit}, 32'd0);
        chk("arst_occupancy", {28'b0, occupancy}, 32'd0);
        chk("arst_branch_count", branch_count, 32'd0);
        chk("arst_mispred_count", mispred_count, 32'd0);
        chk("arst_ready", {31'b0, commit_ready}, 32'd1);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 0;
        idle(12);

        // saturation
        @(negedge clk);
        force dut.branch_cnt = 32'hFFFF_FFFF;
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        release dut.mispred_cnt;
        mbc = 32'hFFFF_FFFF;
        mmc = 32'hFFFF_FFFF;
        t++;
        cycle(1, 32'h0000_6000, 1, 1);
        cycle(1, 32'h0000_6004, 0, 1);
        idle(15);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries never issued, expected 0",
                     exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
